// File: rtl/wb_store_buffer.sv
// wb_store_buffer
//
// Posted-store buffer between write-back and the data cache. Write-back
// pushes (address, data) pairs in one cycle; entries drain in FIFO order
// to the cache with at most one write in flight, using the
// reqcyc/reqack/writeack handshake. Pending addresses, including the one
// in flight, are compared against a load address so the load can stall.
//
// Handshakes:
//   Push side: a store is taken on a rising clk edge when st_valid and
//   st_ready are both 1. st_ready looks only at registered occupancy, so a
//   retire in the same cycle never makes room for that cycle's push.
//   Cache side: reqcyc/req/reqdata/reqtag stay stable until reqack is
//   sampled high. The entry retires when writeack is sampled, either
//   together with reqack or in a later cycle. writeack at any other time
//   is ignored.
//
// Ports:
//   clk, reset (async, active-low)
//   st_valid/st_addr/st_data/st_ready     store push from write-back
//   ld_check_valid/ld_check_addr/ld_hit   load hazard query (combinational)
//   reqcyc/req/reqdata/reqtag             registered cache write request
//   reqack/writeack                       cache responses
//   write_done                            registered one-cycle retire pulse
//   empty                                 no entries and drain FSM idle
//   count                                 occupied entries incl. in flight
module wb_store_buffer #(
  parameter int          DEPTH  = 4,
  parameter logic [9:0]  REQTAG = 10'b1110000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  input  logic [0:63]                  st_addr,
  input  logic [0:63]                  st_data,
  output logic                         st_ready,
  input  logic [0:63]                  ld_check_addr,
  input  logic                         ld_check_valid,
  output logic                         ld_hit,
  output logic                         reqcyc,
  output logic [0:63]                  req,
  output logic [0:63]                  reqdata,
  output logic [9:0]                   reqtag,
  input  logic                         reqack,
  input  logic                         writeack,
  output logic                         write_done,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           reqcyc_q, reqcyc_d;
  logic [0:63]    req_q, req_d;
  logic [0:63]    reqdata_q, reqdata_d;
  logic [9:0]     reqtag_q, reqtag_d;
  logic           write_done_q;

  logic [0:63]    mem_addr_q [DEPTH];
  logic [0:63]    mem_data_q [DEPTH];

  logic           push;
  logic           pop;

  assign st_ready = (count_q != CW'(DEPTH));
  assign push     = st_valid && st_ready;
  assign empty    = (count_q == '0) && (state_q == S_IDLE);

  // Storage carries no reset: occupancy is defined by count/rd_ptr only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= st_addr;
      mem_data_q[wr_ptr_q] <= st_data;
    end
  end

  // Drain FSM. The head entry stays occupied (counted, hit-checked) until
  // writeack retires it.
  always_comb begin
    state_d   = state_q;
    reqcyc_d  = reqcyc_q;
    req_d     = req_q;
    reqdata_d = reqdata_q;
    reqtag_d  = reqtag_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          req_d     = mem_addr_q[rd_ptr_q];
          reqdata_d = mem_data_q[rd_ptr_q];
          reqtag_d  = REQTAG;
          reqcyc_d  = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (reqack) begin
          reqcyc_d = 1'b0;
          reqtag_d = '0;
          if (writeack) begin
            pop     = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        if (writeack) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reqcyc_q     <= 1'b0;
      req_q        <= '0;
      reqdata_q    <= '0;
      reqtag_q     <= '0;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reqcyc_q     <= reqcyc_d;
      req_q        <= req_d;
      reqdata_q    <= reqdata_d;
      reqtag_q     <= reqtag_d;
      write_done_q <= pop;
    end
  end

  // Slot i is occupied when its distance from rd_ptr (mod DEPTH) is below
  // count; this covers the in-flight head entry as well.
  always_comb begin
    logic [PW-1:0] occ_off;
    ld_hit  = 1'b0;
    occ_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_off = PW'(i) - rd_ptr_q;
      if (ld_check_valid && (CW'(occ_off) < count_q) &&
          (mem_addr_q[i] == ld_check_addr)) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign reqcyc     = reqcyc_q;
  assign req        = req_q;
  assign reqdata    = reqdata_q;
  assign reqtag     = reqtag_q;
  assign write_done = write_done_q;
  assign count      = count_q;

endmodule
